// File: rtl/stream_sort5.sv
// Serial-in / serial-out sorter: a burst of N samples is insertion-sorted into a register array
// as it arrives, then streamed out in order. Define STREAM_SORT_DESCEND_EN for descending order.
module stream_sort5 #(
    parameter int N = 5,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_num,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_num,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   arr_r     [N];
    logic [W-1:0]   arr_nxt_s [N];
    logic           keep_s    [N];
    logic [CW-1:0]  count_r;
    logic [IW-1:0]  idx_r;
    logic           in_hs_s;
    logic           out_hs_s;
    logic           load_done_s;
    logic           out_done_s;

    // An occupied entry stays put when it sorts at or before the new sample (keeps equal values stable).
    function automatic logic stays_before(input logic [W-1:0] entry, input logic [W-1:0] sample);
`ifdef STREAM_SORT_DESCEND_EN
        return entry >= sample;
`else
        return entry <= sample;
`endif
    endfunction

    assign in_hs_s     = in_valid & in_ready;
    assign out_hs_s    = out_valid & out_ready;
    assign load_done_s = in_hs_s && (count_r == CW'(N - 1));
    assign out_done_s  = out_hs_s && (idx_r == IW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_done_s) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_OUT: begin
                if (out_done_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // Output decode from state and stored array only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_num   = {W{1'b0}};
        out_last  = 1'b0;
        case (state_r)
            ST_LOAD: begin
                in_ready = 1'b1;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_num   = arr_r[idx_r];
                out_last  = (idx_r == IW'(N - 1));
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Insertion network: entries before the slot hold, the slot takes the sample, the rest shift up
    always_comb begin
        for (int i = 0; i < N; i++) begin
            keep_s[i] = (CW'(i) < count_r) && stays_before(arr_r[i], in_num);
        end
        if (keep_s[0]) begin
            arr_nxt_s[0] = arr_r[0];
        end else begin
            arr_nxt_s[0] = in_num;
        end
        for (int i = 1; i < N; i++) begin
            if (keep_s[i]) begin
                arr_nxt_s[i] = arr_r[i];
            end else if (keep_s[i-1]) begin
                arr_nxt_s[i] = in_num;
            end else begin
                arr_nxt_s[i] = arr_r[i-1];
            end
        end
    end

    // Array, fill count and output index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                arr_r[i] <= {W{1'b0}};
            end
            count_r <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else begin
            if (in_hs_s) begin
                arr_r   <= arr_nxt_s;
                count_r <= count_r + CW'(1);
            end
            if (load_done_s) begin
                idx_r <= {IW{1'b0}};
            end
            if (out_hs_s) begin
                if (out_done_s) begin
                    idx_r   <= {IW{1'b0}};
                    count_r <= {CW{1'b0}};
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end
        end
    end

endmodule
